// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the RV32M divide sequencer: operation encodings
// (funct3[1:0]), FSM state encodings, iteration count and small op decoders.
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIVS_IDLE = 2'b00,
        DIVS_CALC = 2'b01,
        DIVS_DONE = 2'b10
    } div_state_e;

    // funct3[0] clear selects the signed variants (DIV, REM).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // funct3[1] set selects the remainder variants (REM, REMU).
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division step. {rem, quo} is shifted
// left by one, the divisor is trial-subtracted from the new remainder and,
// when that does not borrow, the difference is kept and a 1 enters the
// quotient LSB.
//
// Ports
//   rem_i      partial remainder (always < divisor_i)
//   quo_i      dividend bits still to consume / quotient bits produced so far
//   divisor_i  divisor magnitude
//   rem_o      next partial remainder
//   quo_o      next quotient/dividend word
// -----------------------------------------------------------------------------
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    // The shifted remainder needs XLEN+1 bits: with a divisor near 2^XLEN the
    // remainder can reach XLEN bits before the shift. One more bit on top of
    // that is the borrow that tells us the trial went negative.
    logic [XLEN:0]   shifted_rem;
    logic [XLEN+1:0] trial;

    always_comb begin
        shifted_rem = {rem_i, quo_i[XLEN-1]};
        trial       = {1'b0, shifted_rem} - {2'b00, divisor_i};
        if (!trial[XLEN+1]) begin
            rem_o = trial[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            // Restore: shifted remainder is below the divisor, so it fits.
            rem_o = shifted_rem[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle DIV/DIVU/REM/REMU sequencer for the Execute stage. Accepts an
// operation in IDLE, iterates a restoring divider for DIV_ITERS cycles, applies
// the RISC-V sign rules and presents the result with a one-cycle valid pulse.
// Divide-by-zero and signed overflow bypass the iteration and complete in one
// cycle.
//
// Ports
//   clk     core clock, rising edge
//   reset   synchronous active-high reset
//   start   divide instruction in E; sampled only in IDLE
//   op      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   srca    dividend (forwarded)
//   srcb    divisor (forwarded)
//   kill    abort current operation, return to IDLE without a result
//   busy    high in CALC and DONE (registered)
//   valid   one-cycle completion pulse (registered)
//   result  quotient or remainder, held until the next completion
// -----------------------------------------------------------------------------
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            kill,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state_q,   state_d;
    logic [1:0]       op_q,      op_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic [XLEN-1:0]  rem_q,     rem_d;
    logic [XLEN-1:0]  quo_q,     quo_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             q_neg_q,   q_neg_d;
    logic             r_neg_q,   r_neg_d;
    logic [XLEN-1:0]  result_q,  result_d;

    // Accept-time decode of the incoming operation.
    logic            in_signed;
    logic            in_rem;
    logic            a_neg;
    logic            b_neg;
    logic            div_by_zero;
    logic            overflow;

    // Iteration datapath.
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;

    assign in_signed   = op_is_signed(op);
    assign in_rem      = op_is_rem(op);
    assign a_neg       = in_signed & srca[XLEN-1];
    assign b_neg       = in_signed & srcb[XLEN-1];
    assign div_by_zero = (srcb == '0);
    assign overflow    = in_signed && (srca == MOST_NEG) && (srcb == '1);

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Sign fix is applied to the last step's outputs so the result can be
    // registered on the same edge that enters DONE.
    assign quo_fixed = q_neg_q ? XLEN'(-step_quo) : step_quo;
    assign rem_fixed = r_neg_q ? XLEN'(-step_rem) : step_rem;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        result_d  = result_q;

        unique case (state_q)
            DIVS_IDLE: begin
                if (start) begin
                    if (div_by_zero) begin
                        result_d = in_rem ? srca : '1;
                        state_d  = DIVS_DONE;
                    end else if (overflow) begin
                        result_d = in_rem ? '0 : MOST_NEG;
                        state_d  = DIVS_DONE;
                    end else begin
                        op_d      = op;
                        divisor_d = b_neg ? XLEN'(-srcb) : srcb;
                        quo_d     = a_neg ? XLEN'(-srca) : srca;
                        rem_d     = '0;
                        cnt_d     = '0;
                        q_neg_d   = a_neg ^ b_neg;
                        r_neg_d   = a_neg;
                        state_d   = DIVS_CALC;
                    end
                end
            end

            DIVS_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                    result_d = op_is_rem(op_q) ? rem_fixed : quo_fixed;
                    state_d  = DIVS_DONE;
                end
            end

            // The instruction that started us is still in E this cycle, so a
            // start seen here belongs to it and must not be re-accepted.
            DIVS_DONE: state_d = DIVS_IDLE;

            default:   state_d = DIVS_IDLE;
        endcase

        // Kill overrides everything, including a start in IDLE and the final
        // iteration; the held result must not be disturbed.
        if (kill) begin
            state_d  = DIVS_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset along with control so that a
        // reset mid-operation leaves every register at zero.
        if (reset) begin
            state_q   <= DIVS_IDLE;
            op_q      <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register.
            state_q   <= state_d;
            op_q      <= op_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            result_q  <= result_d;
        end
    end

    // All three outputs come straight from flops.
    assign busy   = (state_q != DIVS_IDLE);
    assign valid  = (state_q == DIVS_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    div_ctrl #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .srca   (srca),
        .srcb   (srcb),
        .kill   (kill),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    always #5 clk = ~clk;

    // Cycle index; inputs are driven and outputs sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] last_res = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference: RISC-V M-extension semantics, using the simulator's own
    // signed/unsigned arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic sgn;
        sgn = ~o[0];
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : 32'h8000_0000;
        if (sgn) return o[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'h0) return 1;
        if (~o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Scoreboard consumer: every valid pulse must match the oldest expectation
    // in both value and cycle.
    exp_t e;
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", {31'h0, valid}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check(e.tag, result, e.res);
                check({e.tag, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", sb_q.size(), 0);
        @(negedge clk);
    endtask

    // Drive one operation in the current (falling-edge) cycle and wait for it.
    task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        exp_t x;
        x.tag = tag;
        x.res = ref_result(o, a, b);
        x.cyc = cyc + ref_latency(o, a, b);
        sb_q.push_back(x);
        last_res = x.res;
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        @(negedge clk);
        start = 1'b0;
        srca  = $urandom;
        srcb  = $urandom;
        check({tag, "_busy"}, {31'h0, busy}, 32'h1);
        wait_drain();
    endtask

    typedef struct {
        string       tag;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vecs[$];
    int   k;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'b00;
        srca  = 32'h0;
        srcb  = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'h0, busy},  32'h0);
        check("reset_valid",  {31'h0, valid}, 32'h0);
        check("reset_result", result,         32'h0);
        reset = 1'b0;
        @(negedge clk);

        vecs.push_back('{"divu_100_7",     DIV_OP_DIVU, 32'd100,       32'd7});
        vecs.push_back('{"remu_100_7",     DIV_OP_REMU, 32'd100,       32'd7});
        vecs.push_back('{"div_m7_2",       DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2});
        vecs.push_back('{"rem_m7_2",       DIV_OP_REM,  32'hFFFF_FFF9, 32'd2});
        vecs.push_back('{"rem_7_m2",       DIV_OP_REM,  32'd7,         32'hFFFF_FFFE});
        vecs.push_back('{"div_by_zero",    DIV_OP_DIV,  32'h0000_1234, 32'h0});
        vecs.push_back('{"remu_by_zero",   DIV_OP_REMU, 32'h0000_1234, 32'h0});
        vecs.push_back('{"div_overflow",   DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{"rem_overflow",   DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{"divu_max_1",     DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1});
        vecs.push_back('{"remu_max_big",   DIV_OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{"divu_big_big",   DIV_OP_DIVU, 32'hFFFF_FFFE, 32'hFFFF_FFFF});
        vecs.push_back('{"div_m8_m3",      DIV_OP_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD});
        vecs.push_back('{"rem_min_3",      DIV_OP_REM,  32'h8000_0000, 32'd3});
        vecs.push_back('{"divu_0_5",       DIV_OP_DIVU, 32'h0,         32'd5});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{$sformatf("rand%0d", i), 2'($urandom_range(3)), $urandom,
                             32'($urandom >> $urandom_range(31))});

        foreach (vecs[i]) issue(vecs[i].tag, vecs[i].o, vecs[i].a, vecs[i].b);

        // Kill in CALC cycle 10: back to IDLE at cycle 11, no pulse, result held.
        k = cyc;
        start = 1'b1; op = DIV_OP_DIVU; srca = 32'd5000; srcb = 32'd3;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy",   {31'h0, busy},  32'h0);
        check("kill_valid",  {31'h0, valid}, 32'h0);
        check("kill_result", result,         last_res);
        repeat (40) @(negedge clk);
        check("kill_result_held", result, last_res);

        // Kill and start together in IDLE: nothing accepted.
        start = 1'b1; kill = 1'b1; op = DIV_OP_DIV; srca = 32'd9; srcb = 32'd0;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_busy", {31'h0, busy}, 32'h0);
        repeat (40) @(negedge clk);

        issue("after_kill", DIV_OP_REM, 32'hFFFF_FC18, 32'd7);

        // Reset at cycle 20 of an operation: all outputs zero.
        k = cyc;
        start = 1'b1; op = DIV_OP_DIV; srca = 32'd12345; srcb = 32'd11;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy",   {31'h0, busy},  32'h0);
        check("midreset_valid",  {31'h0, valid}, 32'h0);
        check("midreset_result", result,         32'h0);
        repeat (40) @(negedge clk);

        issue("after_reset", DIV_OP_DIVU, 32'd81, 32'd9);

        // Back-to-back with start held through DONE: pulses at 33 and 67.
        k = cyc;
        sb_q.push_back('{"b2b_first",  32'd100, k + 33});
        sb_q.push_back('{"b2b_second", 32'd249, k + 67});
        start = 1'b1; op = DIV_OP_DIVU; srca = 32'd1000; srcb = 32'd10;
        @(negedge clk);
        while (cyc < k + 33) begin
            srca = $urandom;
            srcb = $urandom;
            @(negedge clk);
        end
        srca = 32'd999; srcb = 32'd4;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
